mips_regfile: RTL and testbench
===============================

Name: mips_regfile

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS-like core.
- Sits directly upstream of the ALU. Read port A drives ALU input1. Read port B drives ALU input2, or the store-data path when the immediate mux selects the immediate.
- The write port takes write-back data: the ALU result or the memory load data, selected outside this block.
- Register $0 is hard-wired to zero. A debug read port gives the bench a third, non-intrusive read path.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- RESET_VAL, 32'h00000000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raddr_a  input  ADDR_W  read port A index (instruction rs field).
- rdata_a  output  DATA_W  read port A data, feeds ALU input1.
- raddr_b  input  ADDR_W  read port B index (instruction rt field).
- rdata_b  output  DATA_W  read port B data, feeds ALU input2 / store data.
- we  input  1  write enable from the main control unit (RegWrite).
- waddr  input  ADDR_W  write index (rd or rt, selected by RegDst outside this block).
- wdata  input  DATA_W  write-back data.
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read data; combinational, same rules as the A/B read ports.
- wr_count  output  16  count of committed writes (writes to $0 are not counted); saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- While rst_n is low:
  - all registers are forced to RESET_VAL.
  - wr_count is forced to 0.
  - writes are ignored.
  - rdata_a, rdata_b and dbg_data therefore read RESET_VAL, or 0 for index 0.
- Reset release takes effect at the first clk rising edge after rst_n goes high; no write is lost or duplicated across release.
- Reads:
  - combinational (zero-latency), as the single-cycle datapath requires.
  - index 0 always returns 32'h00000000, regardless of RESET_VAL or any write attempt.
- Write commit:
  - on a clk rising edge with we=1 and waddr!=0: reg[waddr] <= wdata.
  - the new value is visible on the read ports after that edge.
- Writes to $0:
  - we=1 with waddr==0 is discarded.
  - it leaves all registers unchanged and does not increment wr_count.
- Same-cycle read and write of the same index: without the optional feature, the read returns the old value.
- All three read ports may select the same or different indices simultaneously with no interaction.
- wr_count:
  - increments by 1 on each committed write.
  - holds at 16'hFFFF and never wraps.
- Reset asserted mid-cycle aborts any pending write immediately; the register contents after reset are RESET_VAL only.
- No X propagation:
  - unknown raddr is not a legal input.
  - we is sampled only on the clk edge.

Optional Feature:
- Macro: MIPS_REGFILE_BYPASS_EN.
- Defined: write-through forwarding on the A and B read ports. When we=1, waddr!=0 and raddr==waddr, rdata returns wdata in the same cycle. The $0 rule still wins: index 0 reads 0 even if bypass conditions hold. dbg_data is never bypassed.
- Undefined: no forwarding; same-cycle read of a register being written returns the pre-write value.

Decomposition:
- Shared package mips_pkg:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, REG_ZERO=0.
  - a reg_addr_t typedef of ADDR_W bits.
  - a word_t typedef of DATA_W bits.
  - the ALU opcode constants (4'b0001 add … 4'b0101 slt) also live here, so control and ALU share them.
- One natural sub-module: mips_regfile_rdport. It is a single read mux applying the $0 rule and, under the macro, the bypass compare. It is instantiated for A, B and debug, with bypass tied off on the debug instance.

Test Plan:
- Reset: hold rst_n=0, then write reg5=32'hDEADBEEF with we=1 -> rdata_a(raddr=5)=0 and wr_count=0 throughout; after release, the same write -> reg5 reads DEADBEEF next cycle and wr_count=1.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF -> rdata_a(0)=0, rdata_b(0)=0, dbg_data(0)=0, and wr_count is unchanged.
- Dual read: write r1=7 and r2=3, then raddr_a=1, raddr_b=2 -> rdata_a=7 and rdata_b=3. Feed both into the ALU with op 4'b0010 -> ALURes=4, zero=0.
- Read-during-write: r9 holds 10; in the same cycle we=1, waddr=9, wdata=20, raddr_a=9 -> rdata_a=10 without MIPS_REGFILE_BYPASS_EN and 20 with it; after the edge, 20 in both builds.
- Async reset mid-operation: load r31=32'h12345678, then pulse rst_n low between clock edges -> r31 reads 0 immediately, without waiting for a clock edge.
- Counter saturation: perform 65537 writes to r4 -> wr_count=16'hFFFF and holds; one more write leaves it at FFFF while r4 still updates.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//
// Shared definitions for the single-cycle MIPS-like core: datapath widths,
// register-file geometry, the $0 index and the ALU operation codes, so that
// control, ALU and register file agree on one set of constants.
//
// Contents:
//   DATA_W, ADDR_W, NUM_REGS, REG_ZERO : datapath / register-file geometry
//   word_t, reg_addr_t                 : data word and register index types
//   alu_op_e                           : ALU operation codes (add .. slt)
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned DATA_W   = 32'd32;
  localparam int unsigned ADDR_W   = 32'd5;
  localparam int unsigned NUM_REGS = 32'd32;
  localparam int unsigned REG_ZERO = 32'd0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // ALU operation codes, shared by the main control decoder and the ALU.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_OR  = 4'b0100,
    ALU_SLT = 4'b0101
  } alu_op_e;

endpackage : mips_pkg

// File: rtl/mips_regfile_rdport.sv
// -----------------------------------------------------------------------------
// mips_regfile_rdport
//
// One combinational read port of the register file. Selects an entry from the
// flattened register array, forces index 0 to zero, and (when the build
// defines MIPS_REGFILE_BYPASS_EN) forwards the in-flight write data when the
// port reads the register being written in the same cycle.
//
// Configuration macro: MIPS_REGFILE_BYPASS_EN (write-through forwarding).
//
// Ports:
//   regs_i      : all register contents, entry 0 is ignored (reads as zero)
//   raddr_i     : read index
//   bypass_en_i : enables forwarding for this port (bypass build only)
//   we_i        : write enable of the write port (bypass build only)
//   waddr_i     : write index (bypass build only)
//   wdata_i     : write data (bypass build only)
//   rdata_o     : read data
// -----------------------------------------------------------------------------
module mips_regfile_rdport #(
  parameter int unsigned DATA_W = 32'd32,
  parameter int unsigned ADDR_W = 32'd5
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]                  raddr_i,
`ifdef MIPS_REGFILE_BYPASS_EN
  input  logic                               bypass_en_i,
  input  logic                               we_i,
  input  logic [ADDR_W-1:0]                  waddr_i,
  input  logic [DATA_W-1:0]                  wdata_i,
`endif
  output logic [DATA_W-1:0]                  rdata_o
);

  import mips_pkg::*;

  logic is_zero_s;

  assign is_zero_s = (raddr_i == ADDR_W'(REG_ZERO));

`ifdef MIPS_REGFILE_BYPASS_EN
  logic fwd_s;

  // Forward only a write that will actually commit; $0 never commits.
  assign fwd_s = bypass_en_i && we_i &&
                 (waddr_i != ADDR_W'(REG_ZERO)) && (waddr_i == raddr_i);

  // Read mux: $0 rule takes priority over forwarding, then array contents.
  always_comb begin
    rdata_o = {DATA_W{1'b0}};
    if (is_zero_s) begin
      rdata_o = {DATA_W{1'b0}};
    end else if (fwd_s) begin
      rdata_o = wdata_i;
    end else begin
      rdata_o = regs_i[raddr_i];
    end
  end
`else
  // Read mux: $0 rule, otherwise array contents (pre-write value).
  always_comb begin
    rdata_o = {DATA_W{1'b0}};
    if (is_zero_s) begin
      rdata_o = {DATA_W{1'b0}};
    end else begin
      rdata_o = regs_i[raddr_i];
    end
  end
`endif

endmodule : mips_regfile_rdport

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
//
// 32 x 32-bit general-purpose register file for the single-cycle core.
// Two combinational operand read ports (A -> ALU input1, B -> ALU input2 /
// store data), one synchronous write port for write-back data, and a third
// non-intrusive debug read port. Register $0 is hard-wired to zero and is
// not stored. wr_count counts committed (non-$0) writes and saturates.
//
// Configuration macro: MIPS_REGFILE_BYPASS_EN -- when defined, ports A and B
// forward same-cycle write data; the debug port never forwards.
//
// Ports:
//   clk      : system clock, writes on rising edge
//   rst_n    : asynchronous active-low reset
//   raddr_a  : read port A index       rdata_a : read port A data
//   raddr_b  : read port B index       rdata_b : read port B data
//   we       : write enable (RegWrite)
//   waddr    : write index             wdata   : write-back data
//   dbg_addr : debug read index        dbg_data: debug read data
//   wr_count : committed write count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module mips_regfile #(
  parameter int unsigned       DATA_W    = 32'd32,
  parameter int unsigned       ADDR_W    = 32'd5,
  parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  import mips_pkg::*;

  localparam int unsigned NUM_ENTRIES = 2**ADDR_W;

  // Entry 0 has no storage: it is $0 and always reads zero.
  logic [DATA_W-1:0]                   regs_q [NUM_ENTRIES-1:1];
  logic [NUM_ENTRIES-1:0][DATA_W-1:0]  regs_flat_s;
  logic                                commit_s;
  logic [15:0]                         cnt_q;
  logic [15:0]                         cnt_d;

  assign commit_s = we && (waddr != ADDR_W'(REG_ZERO));

  // Register array: async reset to RESET_VAL, commit one entry per write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_ENTRIES; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 1; i < NUM_ENTRIES; i++) begin
        if (commit_s && (waddr == ADDR_W'(i))) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  // Flatten the array for the read muxes; slot 0 is a constant zero.
  always_comb begin
    regs_flat_s    = '{default: {DATA_W{1'b0}}};
    regs_flat_s[0] = {DATA_W{1'b0}};
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      regs_flat_s[i] = regs_q[i];
    end
  end

  // Write-counter next state: +1 per committed write, sticky at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (commit_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Write-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wr_count = cnt_q;

  mips_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_a (
    .regs_i      (regs_flat_s),
    .raddr_i     (raddr_a),
`ifdef MIPS_REGFILE_BYPASS_EN
    .bypass_en_i (1'b1),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
`endif
    .rdata_o     (rdata_a)
  );

  mips_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_b (
    .regs_i      (regs_flat_s),
    .raddr_i     (raddr_b),
`ifdef MIPS_REGFILE_BYPASS_EN
    .bypass_en_i (1'b1),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
`endif
    .rdata_o     (rdata_b)
  );

  // Debug port observes committed state only, so forwarding is tied off.
  mips_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport_dbg (
    .regs_i      (regs_flat_s),
    .raddr_i     (dbg_addr),
`ifdef MIPS_REGFILE_BYPASS_EN
    .bypass_en_i (1'b0),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
`endif
    .rdata_o     (dbg_data)
  );

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile
//
// Self-checking bench for mips_regfile: a table of directed vectors (inputs
// applied on the falling edge, combinational reads checked before the next
// rising edge) plus hand-written sequences for reset, async reset
// mid-operation and counter saturation.
// -----------------------------------------------------------------------------
module tb_mips_regfile;

  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int n_checks;
  int n_fail;

`ifdef MIPS_REGFILE_BYPASS_EN
  localparam logic [31:0] RDW_EXP = 32'd20;
`else
  localparam logic [31:0] RDW_EXP = 32'd10;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs [11];

  mips_regfile #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] ed, input logic [15:0] ec);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.ra = ra; v.rb = rb; v.rd = rd;
    v.ea = ea; v.eb = eb; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] alu_res;
    n_checks = 0;
    n_fail   = 0;

    // Rows: expected values are pre-edge reads; the write commits at the edge.
    vecs[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0, 5'd5,
                  32'h0, 32'h0, 32'h0, 16'd0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 5'd5,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1);
    vecs[2]  = mk(1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 16'd1);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 16'd1);
    vecs[4]  = mk(1'b1, 5'd1,  32'd7,        5'd5,  5'd2, 5'd1,
                  32'hDEADBEEF, 32'h0, 32'h0, 16'd1);
    vecs[5]  = mk(1'b1, 5'd2,  32'd3,        5'd1,  5'd5, 5'd1,
                  32'd7, 32'hDEADBEEF, 32'd7, 16'd2);
    vecs[6]  = mk(1'b1, 5'd9,  32'd10,       5'd1,  5'd2, 5'd2,
                  32'd7, 32'd3, 32'd3, 16'd3);
    vecs[7]  = mk(1'b1, 5'd9,  32'd20,       5'd9,  5'd1, 5'd9,
                  RDW_EXP, 32'd7, 32'd10, 16'd4);
    vecs[8]  = mk(1'b0, 5'd0,  32'h0,        5'd9,  5'd9, 5'd9,
                  32'd20, 32'd20, 32'd20, 16'd5);
    vecs[9]  = mk(1'b1, 5'd31, 32'h12345678, 5'd2,  5'd1, 5'd31,
                  32'd3, 32'd7, 32'h0, 16'd5);
    vecs[10] = mk(1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31,
                  32'h12345678, 32'h12345678, 32'h12345678, 16'd6);

    // Reset held: a write attempt to r5 must be ignored.
    rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    raddr_a = 5'd5; raddr_b = 5'd7; dbg_addr = 5'd5;
    #1;
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_count", {16'h0, wr_count}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_rdata_a", rdata_a, 32'h0);
    check("rst_hold_dbg", dbg_data, 32'h0);
    check("rst_hold_count", {16'h0, wr_count}, 32'h0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb; dbg_addr = vecs[i].rd;
      #1;
      check($sformatf("row%0d_a", i), rdata_a, vecs[i].ea);
      check($sformatf("row%0d_b", i), rdata_b, vecs[i].eb);
      check($sformatf("row%0d_dbg", i), dbg_data, vecs[i].ed);
      check($sformatf("row%0d_cnt", i), {16'h0, wr_count}, {16'h0, vecs[i].ec});
      @(negedge clk);
    end

    // Dual read feeding the ALU: r1 - r2 = 7 - 3.
    we = 1'b0; raddr_a = 5'd1; raddr_b = 5'd2;
    #1;
    alu_res = alu_model(ALU_SUB, rdata_a, rdata_b);
    check("alu_sub_res", alu_res, 32'd4);
    check("alu_sub_zero", {31'h0, (alu_res == 32'h0)}, 32'h0);
    @(negedge clk);

    // Async reset between edges, with a pending write to r31.
    raddr_a = 5'd31; raddr_b = 5'd9; dbg_addr = 5'd31;
    we = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D;
    #2;
    check("pre_async_r31", rdata_a, 32'h12345678);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", rdata_a, 32'h0);
    check("async_rst_b", rdata_b, 32'h0);
    check("async_rst_dbg", dbg_data, 32'h0);
    check("async_rst_cnt", {16'h0, wr_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    #1;
    check("post_rst_r31", dbg_data, 32'h0);
    check("post_rst_cnt", {16'h0, wr_count}, 32'h0);
    @(negedge clk);

    // Counter saturation: 65534 writes to r4, then one more, then two beyond.
    we = 1'b1; waddr = 5'd4; dbg_addr = 5'd4;
    for (int i = 0; i < 65534; i++) begin
      wdata = 32'(i);
      @(negedge clk);
    end
    #1;
    check("cnt_fffe", {16'h0, wr_count}, 32'h0000FFFE);
    check("r4_after_65534", dbg_data, 32'd65533);
    wdata = 32'd65534;
    @(negedge clk);
    #1;
    check("cnt_ffff", {16'h0, wr_count}, 32'h0000FFFF);
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    #1;
    check("cnt_sat_1", {16'h0, wr_count}, 32'h0000FFFF);
    check("r4_sat_1", dbg_data, 32'hA5A5A5A5);
    wdata = 32'h5A5A5A5A;
    @(negedge clk);
    #1;
    check("cnt_sat_2", {16'h0, wr_count}, 32'h0000FFFF);
    check("r4_sat_2", dbg_data, 32'h5A5A5A5A);
    we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mips_regfile
